// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// At most one request is ever outstanding: a request is accepted with
// inst_addr_ok_i, and its word returns later with inst_data_ok_i.
interface if_stage_if;
   logic        inst_req_o;
   logic [31:0] inst_addr_o;
   logic        inst_addr_ok_i;
   logic        inst_data_ok_i;
   logic [31:0] inst_rdata_i;

   modport master (
      output inst_req_o,
      output inst_addr_o,
      input  inst_addr_ok_i,
      input  inst_data_ok_i,
      input  inst_rdata_i
   );

   modport slave (
      input  inst_req_o,
      input  inst_addr_o,
      output inst_addr_ok_i,
      output inst_data_ok_i,
      output inst_rdata_i
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues one request at a time, holds a returned word in a one-entry buffer
// while decode is stalled, and handles delayed branches and flush redirects.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.master  bus,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_to_addr_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o,
   output logic        is_in_delayslot_o
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic [31:0] buf_pc;
   logic [31:0] buf_inst;
   logic [31:0] branch_target;
   logic        buf_valid;
   logic        branch_pending;
   logic        delay_next;

   logic        accept;
   logic        data_in;
   logic        deliver_mem;
   logic        deliver_buf;
   logic        to_buffer;
   logic        branch_take;
   logic        slot_unrequested;
   logic        outstanding;

   assign bus.inst_req_o  = (state == S_REQ);
   assign bus.inst_addr_o = fetch_pc;

   // Decode the handshake events of the current cycle.
   always_comb begin
      accept           = (state == S_REQ) && bus.inst_addr_ok_i;
      data_in          = (state == S_WAIT) && !buf_valid && bus.inst_data_ok_i;
      deliver_mem      = data_in && !stall_i;
      to_buffer        = data_in && stall_i;
      deliver_buf      = (state == S_WAIT) && buf_valid && !stall_i;
      branch_take      = branch_flag_i && valid_o && !stall_i;
      slot_unrequested = (fetch_pc == pc_o + 32'd4);
      outstanding      = accept
                      || ((state == S_WAIT) && !buf_valid && !bus.inst_data_ok_i)
                      || ((state == S_DROP) && !bus.inst_data_ok_i);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_REQ;
      end else begin
         state <= state_next;
      end
   end

   // Next state; a flush with a request still in flight must drain it in DROP.
   always_comb begin
      state_next = state;
      if (flush_i) begin
         state_next = outstanding ? S_DROP : S_REQ;
      end else begin
         case (state)
            S_REQ:   if (accept) state_next = S_WAIT;
            S_WAIT:  if (deliver_mem || deliver_buf) state_next = S_REQ;
            S_DROP:  if (bus.inst_data_ok_i) state_next = S_REQ;
            default: state_next = S_REQ;
         endcase
      end
   end

   // Fetch address, address of the in-flight request and the pending branch target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc       <= RESET_PC;
         req_pc         <= 32'h0;
         branch_pending <= 1'b0;
         branch_target  <= 32'h0;
      end else if (flush_i) begin
         fetch_pc       <= flush_pc_i;
         branch_pending <= 1'b0;
      end else begin
         if (accept) begin
            req_pc <= fetch_pc;
            if (branch_pending) begin
               fetch_pc       <= branch_target;
               branch_pending <= 1'b0;
            end else begin
               fetch_pc <= fetch_pc + 32'd4;
            end
         end
         if (branch_take) begin
            if (slot_unrequested && !accept) begin
               branch_pending <= 1'b1;
               branch_target  <= branch_to_addr_i;
            end else begin
               fetch_pc <= branch_to_addr_i;
            end
         end
      end
   end

   // Decode-side outputs, stall buffer and delay-slot tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_o              <= 32'h0;
         inst_o            <= 32'h0;
         valid_o           <= 1'b0;
         is_in_delayslot_o <= 1'b0;
         buf_valid         <= 1'b0;
         buf_pc            <= 32'h0;
         buf_inst          <= 32'h0;
         delay_next        <= 1'b0;
      end else if (flush_i) begin
         inst_o            <= 32'h0;
         valid_o           <= 1'b0;
         is_in_delayslot_o <= 1'b0;
         buf_valid         <= 1'b0;
         delay_next        <= 1'b0;
      end else begin
         if (to_buffer) begin
            buf_valid <= 1'b1;
            buf_pc    <= req_pc;
            buf_inst  <= bus.inst_rdata_i;
         end
         if (deliver_buf) begin
            buf_valid <= 1'b0;
         end
         if (deliver_mem || deliver_buf) begin
            pc_o              <= deliver_buf ? buf_pc : req_pc;
            inst_o            <= deliver_buf ? buf_inst : bus.inst_rdata_i;
            valid_o           <= 1'b1;
            is_in_delayslot_o <= branch_take || delay_next;
            delay_next        <= 1'b0;
         end else begin
            if (!stall_i) begin
               inst_o            <= 32'h0;
               valid_o           <= 1'b0;
               is_in_delayslot_o <= 1'b0;
            end
            delay_next <= delay_next || branch_take;
         end
      end
   end

endmodule
